// File: rtl/vga_capture_rx.sv
// ---------------------------------------------------------------------------
// vga_capture_rx
//   Receive side of a VGA link. Samples hsync/vsync/RGB on pix_en, recovers
//   the pixel coordinates and checks the line/frame timing. Once a number of
//   consecutive frames have matched the timing parameters, one pix_valid
//   strobe is issued per active pixel.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low
//   pix_en_i       pixel-sample enable; inputs are only sampled when 1
//   hsync_i        horizontal sync (asserted level = SYNC_POL)
//   vsync_i        vertical sync   (asserted level = SYNC_POL)
//   red_i/green_i/blue_i   colour channels, COLOR_W bits each
//   pix_valid_o    one-clk strobe per active pixel while locked
//   pix_x_o        active column
//   pix_y_o        active row
//   pix_rgb_o      {red,green,blue} of the strobed pixel
//   frame_start_o  one-clk strobe coincident with pix_valid_o at (0,0)
//   locked_o       timing locked
//   timing_err_o   one-clk strobe when a timing check fails while locked
//
// FSM states
//   state      | meaning
//   SEARCH     | waiting for the first vsync edge after reset
//   MEASURE    | counting consecutive clean frames
//   LOCKED     | timing confirmed, pixel strobes enabled
// ---------------------------------------------------------------------------
module vga_capture_rx #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   COLOR_W     = 4,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic [COLOR_W-1:0]     red_i,
    input  logic [COLOR_W-1:0]     green_i,
    input  logic [COLOR_W-1:0]     blue_i,
    output logic                   pix_valid_o,
    output logic [9:0]             pix_x_o,
    output logic [9:0]             pix_y_o,
    output logic [3*COLOR_W-1:0]   pix_rgb_o,
    output logic                   frame_start_o,
    output logic                   locked_o,
    output logic                   timing_err_o
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] X0      = 11'(H_SYNC + H_BP);
    localparam logic [10:0] X1      = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] Y0      = 11'(V_SYNC + V_BP);
    localparam logic [10:0] Y1      = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    // Stage 1: input capture
    logic                 s1_new_q;
    logic                 s1_hs_q;
    logic                 s1_vs_q;
    logic [3*COLOR_W-1:0] s1_rgb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_new_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_rgb_q <= '0;
        end else begin
            s1_new_q <= pix_en_i;
            if (pix_en_i) begin
                s1_hs_q  <= hsync_i;
                s1_vs_q  <= vsync_i;
                s1_rgb_q <= {red_i, green_i, blue_i};
            end
        end
    end

    // Stage 2: edge detect, counters, checks
    state_t       state_q, state_d;
    logic [3:0]   good_q, good_d;
    logic [10:0]  hcnt_q, hcnt_d;
    logic [10:0]  vcnt_q, vcnt_d;
    logic [10:0]  hedges_q, hedges_d;      // h_edges since the last v_edge
    logic         hs_prev_q, hs_prev_d;    // previous sample asserted
    logic         vs_prev_q, vs_prev_d;
    logic         h_seen_q, h_seen_d;      // a line start exists to measure from
    logic         frame_bad_q, frame_bad_d;

    logic hs_act, vs_act, h_edge, v_edge;
    logic line_fail, frame_fail, sat_fail, any_fail;

    assign hs_act = (s1_hs_q == SYNC_POL);
    assign vs_act = (s1_vs_q == SYNC_POL);
    assign h_edge = s1_new_q & hs_act & ~hs_prev_q;
    assign v_edge = s1_new_q & vs_act & ~vs_prev_q;

    assign line_fail  = h_edge & h_seen_q &
                        (({1'b0, hcnt_q} + 12'd1) != {1'b0, H_TOTAL});
    // The h_edge coincident with a v_edge closes the frame being checked.
    assign frame_fail = v_edge &
                        (({1'b0, hedges_q} + {11'b0, h_edge}) != {1'b0, V_TOTAL});
    // Fires once, on the sample that takes hcnt into saturation.
    assign sat_fail   = s1_new_q & ~h_edge & (hcnt_q == (CNT_MAX - 11'd1));
    assign any_fail   = line_fail | frame_fail | sat_fail;

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        hedges_d    = hedges_q;
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        h_seen_d    = h_seen_q;
        frame_bad_d = frame_bad_q;
        if (s1_new_q) begin
            hs_prev_d = hs_act;
            vs_prev_d = vs_act;
            if (h_edge)
                hcnt_d = '0;
            else if (hcnt_q != CNT_MAX)
                hcnt_d = hcnt_q + 11'd1;
            if (v_edge)
                vcnt_d = '0;
            else if (h_edge && vcnt_q != CNT_MAX)
                vcnt_d = vcnt_q + 11'd1;
            if (v_edge)
                hedges_d = '0;
            else if (h_edge && hedges_q != CNT_MAX)
                hedges_d = hedges_q + 11'd1;
            if (h_edge)
                h_seen_d = 1'b1;
            if (v_edge)
                frame_bad_d = 1'b0;
            else if (line_fail || sat_fail)
                frame_bad_d = 1'b1;
        end
    end

    // FSM process 1: state register (counters share the register block)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SEARCH;
            good_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hedges_q    <= '0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            h_seen_q    <= 1'b0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hedges_q    <= hedges_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            h_seen_q    <= h_seen_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // FSM process 2: next state
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (s1_new_q) begin
            case (state_q)
                ST_SEARCH: begin
                    if (v_edge) begin
                        state_d = ST_MEASURE;
                        good_d  = '0;
                    end
                end
                ST_MEASURE: begin
                    if (any_fail) begin
                        good_d = '0;
                    end else if (v_edge) begin
                        if (frame_bad_q) begin
                            good_d = '0;
                        end else if (good_q + 4'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (any_fail) begin
                        state_d = ST_MEASURE;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            endcase
        end
    end

    // FSM process 3: outputs (computed on the sample's own coordinates)
    logic       active;
    logic [9:0] pix_x_calc, pix_y_calc;
    logic       pix_valid_d, frame_start_d, timing_err_d;

    always_comb begin
        active        = (hcnt_d >= X0) && (hcnt_d < X1) &&
                        (vcnt_d >= Y0) && (vcnt_d < Y1);
        pix_x_calc    = 10'(hcnt_d - X0);
        pix_y_calc    = 10'(vcnt_d - Y0);
        pix_valid_d   = s1_new_q && (state_q == ST_LOCKED) && !any_fail && active;
        frame_start_d = pix_valid_d && (pix_x_calc == 10'd0) && (pix_y_calc == 10'd0);
        timing_err_d  = s1_new_q && (state_q == ST_LOCKED) && any_fail;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid_o   <= 1'b0;
            frame_start_o <= 1'b0;
            timing_err_o  <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            pix_rgb_o     <= '0;
        end else begin
            pix_valid_o   <= pix_valid_d;
            frame_start_o <= frame_start_d;
            timing_err_o  <= timing_err_d;
            if (pix_valid_d) begin
                pix_x_o   <= pix_x_calc;
                pix_y_o   <= pix_y_calc;
                pix_rgb_o <= s1_rgb_q;
            end
        end
    end

    assign locked_o = (state_q == ST_LOCKED);

endmodule
